// File: rtl/uart_pkg.sv
// uart_pkg: shared UART arbiter state type and default UART core constants
package uart_pkg;
    typedef enum logic [1:0] {ARB, START, WAIT_DONE} arb_state_t;
    localparam int UART_WIDTH = 8;
    localparam int CLK_FREQ   = 50_000_000;
    localparam int BAUD_RATE  = 115_200;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: first set bit of req at or above ptr, wrapping to 0
//   req   : request vector
//   ptr   : scan start index
//   found : any request set
//   idx   : winning index
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);
    logic [2*N-1:0] dbl;
    // Lower copy masked below ptr, upper copy intact: the lowest set bit is the wrapped winner.
    always_comb begin
        dbl   = {req, req} & ({2*N{1'b1}} << ptr);
        found = |req;
        idx   = '0;
        for (int i = 2*N-1; i >= 0; i--)
            if (dbl[i]) idx = IW'(i % N);
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART TX core among NUM_REQ requesters
//   req_valid/req_data/req_last : per-requester byte, data slice [i*WIDTH +: WIDTH]
//   req_ready                   : one-hot acceptance pulse, coincident with tx_start
//   tx_start/tx_data            : start pulse and held byte to the UART TX core
//   tx_busy/tx_done             : core status and end-of-byte pulse
//   grant_id/grant_valid        : current or last grant, transfer in flight
//   UART_ARB_LOCK_EN            : keep the grant on one requester until req_last
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = UART_WIDTH,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     tx_start,
    output logic [WIDTH-1:0]         tx_data,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic [ID_W-1:0]          grant_id,
    output logic                     grant_valid
);
    arb_state_t         state, nxt;
    logic [ID_W-1:0]    rr_ptr, win, nxt_ptr;
    logic [NUM_REQ-1:0] cand;
    logic               found, go;
`ifdef UART_ARB_LOCK_EN
    logic lock;
    // A locked message only competes with itself.
    assign cand = lock ? (req_valid & (NUM_REQ'(1) << grant_id)) : req_valid;
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign cand = req_valid;
`endif
    rr_picker #(.N(NUM_REQ), .IW(ID_W)) u_pick (
        .req   (cand),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (win)
    );
    assign go      = (state == ARB) && !tx_busy && found;
    assign nxt_ptr = (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
    always_comb begin
        nxt         = (state == ARB)   ? (go ? START : ARB) :
                      (state == START) ? WAIT_DONE :
                      (tx_done ? ARB : WAIT_DONE);
        tx_start    = state == START;
        req_ready   = tx_start ? (NUM_REQ'(1) << grant_id) : '0;
        grant_valid = (state == START) || (state == WAIT_DONE);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB;
            rr_ptr   <= '0;
            grant_id <= '0;
            tx_data  <= '0;
`ifdef UART_ARB_LOCK_EN
            lock     <= 1'b0;
`endif
        end else begin
            state <= nxt;
            if (go) begin
                grant_id <= win;
                tx_data  <= req_data[win*WIDTH +: WIDTH];
`ifdef UART_ARB_LOCK_EN
                lock <= !req_last[win];
                if (req_last[win]) rr_ptr <= nxt_ptr;
`else
                rr_ptr <= nxt_ptr;
`endif
            end
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing one UART transmitter among `NUM_REQ` byte-stream requesters. It sits between the requester blocks and the UART TX core, which drives the serial line. It grants one requester per byte, issues a single-cycle `tx_start` with a held `tx_data` byte, and waits for the core's `tx_done` pulse before arbitrating again. An optional lock mode keeps the grant on one requester for the whole multi-byte message.

## Interface
Reset is asynchronous and active-high. All logic is clocked on `clk`.

Parameters:
- `NUM_REQ`, default 4: number of requesters. Must be ≥ 2.
- `WIDTH`, default 8: byte width, matching the UART core.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the grant index (localparam).

Ports:
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input `NUM_REQ`: requester i has a byte pending.
- `req_data` input `NUM_REQ*WIDTH`: byte for requester i in slice `[i*WIDTH +: WIDTH]`. Must stay stable while `req_valid[i]` is high and `req_ready[i]` is low.
- `req_last` input `NUM_REQ`: the pending byte is the last of its message. Used only when `UART_ARB_LOCK_EN` is defined.
- `req_ready` output `NUM_REQ`: one-hot, one-cycle acceptance pulse.
- `tx_start` output 1: one-cycle start pulse to the UART TX core.
- `tx_data` output `WIDTH`: byte to transmit. Held from grant until the next grant.
- `tx_busy` input 1: the UART TX core is busy.
- `tx_done` input 1: one-cycle pulse, byte fully sent including the stop bit.
- `grant_id` output `ID_W`: index of the current or last granted requester.
- `grant_valid` output 1: a transfer is in flight (state is START or WAIT_DONE).

## Operation
State machine `arb_state_t` with three states:
- **ARB**
  - Grant is allowed only when `tx_busy`=0 and some `req_valid` bit is high.
  - The winner is the first set bit of `req_valid`, scanning upward from `rr_ptr` with wrap from `NUM_REQ-1` to 0.
  - On a grant: latch `grant_id` and `tx_data` from the winner's slice, set `rr_ptr` to (winner+1) mod `NUM_REQ`, and go to START.
  - With no grant, stay in ARB.
- **START**
  - Assert `tx_start`=1 and `req_ready[grant_id]`=1 for exactly this cycle, then go to WAIT_DONE unconditionally.
- **WAIT_DONE**
  - Hold `tx_data` and `grant_id`.
  - On `tx_done`=1, return to ARB.

Boundary rules:
- `tx_done` seen in ARB or START is ignored. It must not advance state.
- If `req_valid[i]` drops before START, the byte latched at grant is still sent. Requesters must not withdraw a request; a bench must flag any withdrawal.
- `tx_busy`=1 in ARB blocks granting, so the arbiter never fires `tx_start` into a busy core.
- All requesters valid: service order is strictly i, i+1, …, wrapping around. No requester waits more than `NUM_REQ-1` bytes.
- Reset mid-transfer returns the state to ARB immediately. The UART core is not aborted. Any later `tx_done` arriving in ARB is ignored per the rule above.

## Timing
- Reset values:
  - state ARB, `rr_ptr` 0
  - `req_ready` 0, `tx_start` 0, `tx_data` 0
  - `grant_id` 0, `grant_valid` 0
- Latency: `req_valid` high in cycle N (with ARB and `tx_busy`=0) gives `tx_start` and `req_ready` in cycle N+1.
- Turnaround: `tx_done` in cycle M gives ARB in M+1 and the next `tx_start` no earlier than M+2.
- `req_ready` and `tx_start` are always coincident. Each is high for exactly one cycle per byte.

## Configuration
Macro: `UART_ARB_LOCK_EN`.
- **Defined:**
  - A grant whose latched `req_last`=0 sets `lock`. While `lock`=1, ARB considers only `grant_id`.
  - If that requester has no valid byte, ARB waits with no timeout.
  - The byte latched with `req_last`=1 clears `lock` on its grant.
  - `rr_ptr` advances only when `lock` clears.
  - Reset clears `lock`.
- **Not defined:** `req_last` is ignored, no lock register exists, and round-robin is re-evaluated on every byte.

## Structure
- Shared package `uart_pkg` holds the `arb_state_t` enum (ARB, START, WAIT_DONE; 2-bit logic) and the default `WIDTH`, `CLK_FREQ` and `BAUD_RATE` constants used by the UART cores.
- One combinational sub-module, `rr_picker`:
  - Inputs: `req` vector, `ptr`.
  - Outputs: `found` and `idx`.
  - Implemented with a double-width mask scan.
- The FSM, latches and lock logic stay in `uart_tx_arbiter`.

## Test plan
- **Reset:** assert `rst` mid-WAIT_DONE → all outputs 0, state ARB; a stray `tx_done` 3 cycles later causes no `tx_start`.
- **Single requester:** `req_valid`=4'b0100, `req_data[2]`=8'hA5 → `tx_start` and `req_ready`=4'b0100 one cycle later, `tx_data`=8'hA5, `grant_id`=2; returns to ARB the cycle after `tx_done`.
- **All requesters valid, no lock, starting from reset:** over 6 bytes, grant order is 0,1,2,3,0,1, and every `tx_start` comes ≥2 cycles after the previous `tx_done`.
- **`tx_busy` held 1 for 20 cycles with requests pending:** no `tx_start`; the grant comes 1 cycle after `tx_busy` falls.
- **Lock (`UART_ARB_LOCK_EN` defined):**
  - Stimulus: requester 1 sends 3 bytes (`req_last`=0,0,1) while requesters 0, 2 and 3 stay valid.
  - Grants: 1,1,1 then 2.
  - Without the macro, the same stimulus gives 1,2,3,0.
